// File: rtl/concat_word_buf.sv
// concat_word_buf: output word buffer between the shift-concatenation stage and the
// encryption stage. A FIFO of {last,data} entries with back-pressure toward the packer,
// a valid/ready read side, and a per-message word counter.
// Optional feature macro: WORD_BUF_BYPASS_EN. When it is defined, an empty buffer forwards
// wr_data/wr_last combinationally to the read side.
module concat_word_buf #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AF_MARGIN = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic [63:0]      i_wr_data,
    input  logic             i_wr_done,
    input  logic             i_wr_last,
    output logic             o_stall,
    output logic             o_almost_full,
    output logic [63:0]      o_rd_data,
    output logic             o_rd_last,
    output logic             o_rd_valid,
    input  logic             i_rd_ready,
    output logic [CNT_W-1:0] o_msg_words,
    output logic             o_msg_done
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_LVL   = (AW+1)'(DEPTH - AF_MARGIN);

    logic [64:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [CNT_W-1:0] r_word_cnt;
    logic [CNT_W-1:0] r_msg_words;
    logic             r_msg_done;

    logic             w_full;
    logic             w_empty;
    logic             w_clear;
    logic             w_push;
    logic             w_pop;
    logic             w_store;
    logic             w_deq;
    logic             w_byp_vld;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [64:0]      w_rd_word;

    assign w_full  = (r_count == FULL_LVL);
    assign w_empty = (r_count == '0);
    assign w_clear = ~i_rst | i_flush;

`ifdef WORD_BUF_BYPASS_EN
    // Gated by reset/flush so a cleared cycle never presents or consumes a word.
    assign w_byp_vld = w_empty & i_wr_done & i_rst & ~i_flush;
`else
    assign w_byp_vld = 1'b0;
`endif

    assign w_push  = i_wr_done & ~w_full;
    assign o_rd_valid = ~w_empty | w_byp_vld;
    assign w_pop   = o_rd_valid & i_rd_ready;
    // A bypassed word that is accepted immediately never enters storage.
    assign w_store = w_push & ~(w_byp_vld & i_rd_ready);
    assign w_deq   = w_pop & ~w_empty;

    assign w_rd_word = w_byp_vld ? {i_wr_last, i_wr_data} : r_mem[r_rd_ptr];
    assign o_rd_data = w_rd_word[63:0];
    assign o_rd_last = w_rd_word[64];

    assign o_stall       = w_full;
    assign o_almost_full = (r_count >= AF_LVL);
    assign o_msg_words   = r_msg_words;
    assign o_msg_done    = r_msg_done;

    // Saturating increment of the running word count.
    assign w_cnt_inc = (r_word_cnt == '1) ? r_word_cnt : r_word_cnt + CNT_W'(1);

    // Storage array: written on store, never cleared.
    always_ff @(posedge i_clk) begin
        if (w_store && !w_clear) begin
            r_mem[r_wr_ptr] <= {i_wr_last, i_wr_data};
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge i_clk) begin
        if (!i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_store, w_deq})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Per-message word counter and completion report.
    always_ff @(posedge i_clk) begin
        if (!i_rst || i_flush) begin
            r_word_cnt  <= '0;
            r_msg_words <= '0;
            r_msg_done  <= 1'b0;
        end else begin
            r_msg_done <= 1'b0;
            if (w_push) begin
                if (i_wr_last) begin
                    r_msg_words <= w_cnt_inc;
                    r_msg_done  <= 1'b1;
                    r_word_cnt  <= '0;
                end else begin
                    r_word_cnt <= w_cnt_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_concat_word_buf.sv
// Bench for concat_word_buf: randomized stimulus against a queue-based reference model,
// with a scoreboard monitor comparing outputs on the falling clock edge.
module tb_concat_word_buf;

    localparam int DEPTH = 8;
    localparam int AFM   = 2;
    localparam int CW    = 4;
    localparam int MAXC  = (1 << CW) - 1;
`ifdef WORD_BUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_flush;
    logic [63:0]   i_wr_data;
    logic          i_wr_done;
    logic          i_wr_last;
    logic          o_stall;
    logic          o_almost_full;
    logic [63:0]   o_rd_data;
    logic          o_rd_last;
    logic          o_rd_valid;
    logic          i_rd_ready;
    logic [CW-1:0] o_msg_words;
    logic          o_msg_done;

    concat_word_buf #(
        .DEPTH     (DEPTH),
        .AF_MARGIN (AFM),
        .CNT_W     (CW)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_flush       (i_flush),
        .i_wr_data     (i_wr_data),
        .i_wr_done     (i_wr_done),
        .i_wr_last     (i_wr_last),
        .o_stall       (o_stall),
        .o_almost_full (o_almost_full),
        .o_rd_data     (o_rd_data),
        .o_rd_last     (o_rd_last),
        .o_rd_valid    (o_rd_valid),
        .i_rd_ready    (i_rd_ready),
        .o_msg_words   (o_msg_words),
        .o_msg_done    (o_msg_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          stall;
        logic          valid;
        logic          af;
        logic          md;
        logic [CW-1:0] mw;
    } st_t;

    st_t         st_q[$];
    logic [64:0] sb_q[$];

    // Reference model state: occupancy and message bookkeeping.
    int          occ  = 0;
    int          wcnt = 0;
    logic        md   = 1'b0;
    logic [CW-1:0] mw = '0;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: per-cycle status plus in-order word check on every accepted read.
    always @(negedge clk) begin
        st_t e;
        if (st_q.size() != 0) begin
            e = st_q.pop_front();
            chk("stall",       65'(o_stall),       65'(e.stall));
            chk("rd_valid",    65'(o_rd_valid),    65'(e.valid));
            chk("almost_full", 65'(o_almost_full), 65'(e.af));
            chk("msg_done",    65'(o_msg_done),    65'(e.md));
            chk("msg_words",   65'(o_msg_words),   65'(e.mw));
            if (o_rd_valid === 1'b1 && i_rd_ready) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rd_word at %0t: got %h expected no word", $time,
                             {o_rd_last, o_rd_data});
                end else begin
                    chk("rd_word", {o_rd_last, o_rd_data}, sb_q.pop_front());
                end
            end
        end
    end

    function automatic int sat_inc(input int v);
        return (v + 1 > MAXC) ? MAXC : v + 1;
    endfunction

    // One clock of stimulus; records expected status and advances the model.
    task automatic drive(input bit rn, input bit fl, input bit dn, input logic [63:0] d,
                         input bit lt, input bit rdy, output bit pushed);
        st_t e;
        bit  pop;
        @(posedge clk);
        #1;
        i_rst      = rn;
        i_flush    = fl;
        i_wr_done  = dn;
        i_wr_data  = d;
        i_wr_last  = lt;
        i_rd_ready = rdy;
        e.stall = (occ == DEPTH);
        e.valid = (occ != 0) || (BYP && dn && rn && !fl);
        e.af    = (occ >= DEPTH - AFM);
        e.md    = md;
        e.mw    = mw;
        st_q.push_back(e);
        pushed = 1'b0;
        if (!rn || fl) begin
            occ  = 0;
            sb_q.delete();
            wcnt = 0;
            mw   = '0;
            md   = 1'b0;
        end else begin
            pushed = dn && (occ < DEPTH);
            pop    = rdy && ((occ != 0) || (BYP && dn));
            if (pushed) sb_q.push_back({lt, d});
            occ = occ + int'(pushed) - int'(pop);
            md  = 1'b0;
            if (pushed) begin
                if (lt) begin
                    mw   = CW'(sat_inc(wcnt));
                    md   = 1'b1;
                    wcnt = 0;
                end else begin
                    wcnt = sat_inc(wcnt);
                end
            end
        end
    endtask

    // rmode: 0 never ready, 1 always ready, 2 random.
    task automatic send(input logic [63:0] d, input bit lt, input int rmode);
        bit p;
        int n;
        n = 0;
        do begin
            drive(1'b1, 1'b0, 1'b1, d, lt,
                  (rmode == 1) || (rmode == 2 && ($urandom % 2 == 0)), p);
            n++;
        end while (!p && n < 64);
        if (!p) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout at %0t: got no push expected push of %h", $time, d);
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        bit p;
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 64'($urandom), 1'b0, rdy, p);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (occ != 0 && n < 64) begin
            idle(1, 1'b1);
            n++;
        end
        idle(1, 1'b1);
    endtask

    initial begin
        bit p;
        i_rst      = 1'b0;
        i_flush    = 1'b0;
        i_wr_done  = 1'b1;
        i_wr_data  = 64'h0;
        i_wr_last  = 1'b0;
        i_rd_ready = 1'b0;

        // Reset held two cycles with done asserted, then release with no push.
        drive(1'b0, 1'b0, 1'b1, 64'h55, 1'b0, 1'b0, p);
        drive(1'b0, 1'b0, 1'b1, 64'h66, 1'b0, 1'b0, p);
        idle(3, 1'b0);

        // Fill to full, hold the ninth word, then drain.
        for (int i = 1; i <= 8; i++) send(64'(i), 1'b0, 0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 64'h9, 1'b0, 1'b0, p);
        send(64'h9, 1'b0, 1);
        drain();

        // Streaming back-to-back with the reader always ready.
        for (int i = 0; i < 100; i++) send({$urandom, $urandom}, 1'b0, 1);
        drain();

        // Five-word message then a one-word message.
        for (int i = 1; i <= 5; i++) send({$urandom, $urandom}, i == 5, 2);
        idle(2, 1'b1);
        send(64'hABCD, 1'b1, 1);
        drain();

        // Flush mid-message, then a two-word message.
        for (int i = 0; i < 3; i++) send(64'(100 + i), 1'b0, 0);
        drive(1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, p);
        idle(1, 1'b0);
        send(64'h200, 1'b0, 0);
        send(64'h201, 1'b1, 0);
        drain();

        // Empty buffer, word offered with reader ready.
        drive(1'b1, 1'b0, 1'b1, 64'hDEADBEEF, 1'b0, 1'b1, p);
        drain();

        // Long message saturates the word counter.
        for (int i = 1; i <= 20; i++) send(64'(i), i == 20, 1);
        drain();

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            bit rn, fl, dn, rdy;
            rn  = ($urandom % 100) != 0;
            fl  = ($urandom % 50) == 0;
            dn  = ($urandom % 4) != 0;
            rdy = (rn && !fl) && ((i < 200) ? ($urandom % 3 == 0) : ($urandom % 4 != 0));
            drive(rn, fl, dn, {$urandom, $urandom}, ($urandom % 6) == 0, rdy, p);
        end
        drain();
        idle(2, 1'b1);

        @(negedge clk);
        #1;
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drained: got %0d words left expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
